// File: rtl/flasher_pkg.sv
// Shared definitions for blocks that drive or observe a Bound_Flasher lamp bar.
package flasher_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    PULSE,
    WAIT_START,
    RUN,
    DONE,
    ERR
  } state_e;

  localparam int DEF_N             = 4;
  localparam int DEF_LAMPS         = 16;
  localparam int DEF_FLICK_CYC     = 2;
  localparam int DEF_SETTLE_CYC    = 4;
  localparam int DEF_START_TIMEOUT = 8;
  localparam int DEF_RUN_TIMEOUT   = 255;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] pick_idx,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    idx      = '0;
    for (int off = 0; off < N; off++) begin
      idx = PW'((int'(ptr) + off) % N);
      if (!valid && req[idx]) begin
        valid     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/flasher_flick_sched.sv
// Shares one Bound_Flasher between N requesters: grants round-robin, waits for a dark
// bar, pulses flick, tracks the run on lamp and reports done/err to the owner.
module flasher_flick_sched
  import flasher_pkg::*;
#(
  parameter int N             = DEF_N,
  parameter int LAMPS         = DEF_LAMPS,
  parameter int FLICK_CYC     = DEF_FLICK_CYC,
  parameter int SETTLE_CYC    = DEF_SETTLE_CYC,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int RUN_TIMEOUT   = DEF_RUN_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     kick,
  input  logic [LAMPS-1:0] lamp,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     done,
  output logic [N-1:0]     err,
  output logic             flick,
  output logic             busy
);

  localparam int PW      = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_MAX = max_of(max_of(FLICK_CYC, SETTLE_CYC),
                                  max_of(START_TIMEOUT, RUN_TIMEOUT));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] kcnt_q, kcnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [N-1:0]     done_q, done_d;
  logic [N-1:0]     err_q, err_d;
  logic             flick_q, flick_d;
  logic             busy_q, busy_d;

  logic [N-1:0]     pick;
  logic [PW-1:0]    pick_idx;
  logic             pick_vld;
  logic             dark;

  assign dark = (lamp == '0);

  rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kcnt_d  = kcnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    flick_d = flick_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!dark) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          flick_d = 1'b1;
          cnt_d   = '0;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_W'(FLICK_CYC - 1)) begin
          flick_d = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_START: begin
        if (!dark) begin
          cnt_d   = '0;
          kcnt_d  = '0;
          state_d = RUN;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          err_d   = gnt_q;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        // Dark ends the run even if a kick pulse is still in flight.
        if (dark) begin
          done_d  = gnt_q;
          flick_d = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(RUN_TIMEOUT - 1)) begin
          err_d   = gnt_q;
          flick_d = 1'b0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (flick_q) begin
            if (kcnt_q == CNT_W'(FLICK_CYC - 1)) begin
              flick_d = 1'b0;
              kcnt_d  = '0;
            end else begin
              kcnt_d = kcnt_q + 1'b1;
            end
          end else if (kick[owner_q]) begin
            flick_d = 1'b1;
            kcnt_d  = '0;
          end
        end
      end
      DONE, ERR: begin
        gnt_d   = '0;
        flick_d = 1'b0;
        ptr_d   = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kcnt_q  <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      flick_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kcnt_q  <= kcnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      flick_q <= flick_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign err   = err_q;
  assign flick = flick_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_flasher_flick_sched.sv
// Directed bench for flasher_flick_sched: cycle table for a full run, then
// hand sequences for arbitration, settle, timeouts, kicks and async reset.
module tb_flasher_flick_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  kick;
  logic [15:0] lamp;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  err;
  logic        flick;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  flasher_flick_sched #(
    .N(4), .LAMPS(16), .FLICK_CYC(2), .SETTLE_CYC(4),
    .START_TIMEOUT(8), .RUN_TIMEOUT(255)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .kick  (kick),
    .lamp  (lamp),
    .gnt   (gnt),
    .done  (done),
    .err   (err),
    .flick (flick),
    .busy  (busy)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  kick;
    logic [15:0] lamp;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        flick;
    logic        busy;
  } vec_t;

  vec_t vecs[64];
  int   n_vecs = 0;

  task automatic add_vec(input logic [3:0] r, input logic [3:0] k, input logic [15:0] l,
                         input logic [3:0] g, input logic [3:0] d, input logic [3:0] e,
                         input logic f, input logic b);
    vecs[n_vecs] = '{r, k, l, g, d, e, f, b};
    n_vecs++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] obs();
    return {gnt, done, err, flick, busy};
  endfunction

  task automatic wait_gnt();
    int n = 0;
    while (gnt == 4'b0 && n < 20) begin step(); n++; end
  endtask

  // Waits for the start pulse to rise and fall; leaves time just after the fall edge.
  task automatic wait_pulse(input string name);
    int n = 0;
    while (!flick && n < 20) begin step(); n++; end
    check({name, "_pulse_rise"}, flick, 1);
    n = 0;
    while (flick && n < 10) begin step(); n++; end
  endtask

  task automatic run_one(input int own);
    int n;
    wait_gnt();
    check("rr_gnt", gnt, 4'b0001 << own);
    wait_pulse("rr");
    lamp = 16'h00f0;
    repeat (5) step();
    lamp = 16'h0000;
    n = 0;
    while (done == 4'b0 && n < 10) begin step(); n++; end
    check("rr_done", done, 4'b0001 << own);
    step();
    check("rr_release", {gnt, busy}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    int   n;
    logic pat [6];

    // Full single-request run, one row per clock: inputs before the edge, outputs after.
    add_vec(4'b0001, 4'b0, 16'h0, 4'b0001, 4'b0, 4'b0, 1'b0, 1'b1);
    add_vec(4'b0001, 4'b0, 16'h0, 4'b0001, 4'b0, 4'b0, 1'b0, 1'b1);
    for (int i = 2; i < 4; i++) add_vec(4'b0, 4'b0, 16'h0, 4'b0001, 4'b0, 4'b0, 1'b0, 1'b1);
    for (int i = 4; i < 6; i++) add_vec(4'b0, 4'b0, 16'h0, 4'b0001, 4'b0, 4'b0, 1'b1, 1'b1);
    for (int i = 6; i < 8; i++) add_vec(4'b0, 4'b0, 16'h0, 4'b0001, 4'b0, 4'b0, 1'b0, 1'b1);
    for (int i = 8; i < 38; i++) add_vec(4'b0, 4'b0, 16'h1, 4'b0001, 4'b0, 4'b0, 1'b0, 1'b1);
    add_vec(4'b0, 4'b0, 16'h0, 4'b0001, 4'b0001, 4'b0, 1'b0, 1'b1);
    add_vec(4'b0, 4'b0, 16'h0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    add_vec(4'b0, 4'b0, 16'h0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    rst  = 1'b1;
    req  = '0;
    kick = '0;
    lamp = '0;
    repeat (2) step();
    rst = 1'b0;
    check("reset_outputs", obs(), 0);

    for (int i = 0; i < n_vecs; i++) begin
      req  = vecs[i].req;
      kick = vecs[i].kick;
      lamp = vecs[i].lamp;
      step();
      check($sformatf("vec%0d", i), obs(),
            {vecs[i].gnt, vecs[i].done, vecs[i].err, vecs[i].flick, vecs[i].busy});
    end

    // Round robin from pointer 0 with requesters 0, 1 and 3 held.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1011;
    run_one(0);
    run_one(1);
    run_one(3);
    run_one(0);
    req = 4'b0;

    // Settle blocked by a lit bar; then start timeout on requester 0.
    lamp = 16'h0001;
    req  = 4'b0001;
    step();
    check("settle_gnt", gnt, 4'b0001);
    req  = 4'b0011;
    seen = 0;
    repeat (9) begin step(); seen |= int'(flick); end
    check("settle_blocked", seen, 0);
    lamp = 16'h0;
    seen = 0;
    repeat (3) begin step(); seen |= int'(flick); end
    check("settle_early", seen, 0);
    step();
    check("settle_rise", flick, 1);
    step();
    check("pulse_hi2", flick, 1);
    step();
    check("pulse_fall", flick, 0);
    seen = 0;
    repeat (7) begin step(); seen |= int'(err); end
    check("start_to_early", seen, 0);
    step();
    check("start_to_err", {err, gnt, busy}, {4'b0001, 4'b0001, 1'b1});
    step();
    check("err_release", {err, gnt, busy}, 0);
    step();
    check("next_gnt", gnt, 4'b0010);
    req = 4'b0;

    // Kicks during requester 1's run.
    wait_pulse("kick");
    lamp = 16'h8000;
    step();
    check("run_entry", {flick, busy}, {1'b0, 1'b1});
    kick = 4'b0001;
    step();
    kick = 4'b0;
    seen = int'(flick);
    step();
    seen |= int'(flick);
    check("nonowner_kick", seen, 0);
    kick = 4'b0010;
    step();
    kick = 4'b0;
    check("kick_rise", flick, 1);
    step();
    check("kick_hi2", flick, 1);
    step();
    check("kick_fall", flick, 0);
    step();
    check("kick_single", flick, 0);
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    kick = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("kick_hold%0d", k), flick, pat[k]);
    end
    kick = 4'b0;
    step();
    check("kick_hold_end", flick, 0);
    kick = 4'b0010;
    step();
    kick = 4'b0;
    check("kick_before_dark", flick, 1);
    lamp = 16'h0;
    step();
    check("done_wins", {flick, done, gnt}, {1'b0, 4'b0010, 4'b0010});
    step();
    check("done_release", {gnt, busy}, 0);

    // Asynchronous reset mid-run with flick high; pointer returns to 0.
    req = 4'b0100;
    wait_gnt();
    check("gnt_2", gnt, 4'b0100);
    req = 4'b0;
    wait_pulse("rst");
    lamp = 16'h0003;
    step();
    kick = 4'b0100;
    step();
    check("pre_reset_flick", flick, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {flick, gnt, busy}, 0);
    kick = 4'b0;
    lamp = 16'h0;
    req  = 4'b0110;
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_reset_gnt", gnt, 4'b0010);
    req = 4'b0;

    // Run timeout: bar never goes dark.
    wait_pulse("run_to");
    lamp = 16'h0100;
    step();
    n = 0;
    while (err == 4'b0 && n < 300) begin step(); n++; end
    check("run_timeout_cycles", n, 255);
    check("run_timeout_err", err, 4'b0010);
    lamp = 16'h0;
    step();
    check("run_timeout_release", {gnt, busy, err}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
